// File: rtl/dda_param_loader.sv
// dda_param_loader: byte-wide parameter loader and step sequencer for the
// posit DDA core. Holds the five N-bit operands plus a step prescaler, and
// drives the core's rst_n/en pins: one INIT cycle, then paced integration steps.
// Optional feature macro: STEP_EN (single-step requests from IDLE via 'step').
module dda_param_loader #(
  parameter int N     = 16,
  parameter int ES    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             ptr_clr,
  input  logic             run,
  input  logic             step,
  output logic [N-1:0]     ic1,
  output logic [N-1:0]     ic2,
  output logic [N-1:0]     vK_M,
  output logic [N-1:0]     vD_M,
  output logic [N-1:0]     dt,
  output logic             dda_rst_n,
  output logic             dda_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             err
);

  localparam int BPW    = N / 8;
  localparam int NBYTES = 5 * BPW + 1;
  localparam int PTR_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t              state;
  logic [NBYTES*8-1:0] regs;
  logic [PTR_W-1:0]    ptr;
  logic [7:0]          presc;
  logic [7:0]          pc;

  // ES only travels alongside the operands to the core; nothing here uses it.
  logic [ES:0] unused_es;
  assign unused_es = '0;

`ifdef STEP_EN
  logic step_q;
  logic inited;
  logic step_pend;
  logic step_rise;
  assign step_rise = step & ~step_q;
`else
  logic unused_step;
  assign unused_step = step;
`endif

  // Operands come straight out of the little-endian byte store.
  assign ic1   = regs[0*N +: N];
  assign ic2   = regs[1*N +: N];
  assign vK_M  = regs[2*N +: N];
  assign vD_M  = regs[3*N +: N];
  assign dt    = regs[4*N +: N];
  assign presc = regs[5*N +: 8];

  // Byte write port: stores at ptr only while idle, flags writes made while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      ptr  <= '0;
      err  <= 1'b0;
    end else if (ptr_clr) begin
      ptr <= '0;
      err <= 1'b0;
    end else if (wr_en) begin
      if (state == IDLE) begin
        regs[{ptr, 3'b000} +: 8] <= wr_data;
        if (ptr == PTR_W'(NBYTES - 1)) ptr <= '0;
        else                           ptr <= ptr + 1'b1;
      end else begin
        err <= 1'b1;
      end
    end
  end

  // Sequencer: IDLE -> INIT (core latches ic) -> RUN with prescaled en pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dda_rst_n <= 1'b0;
      dda_en    <= 1'b0;
      step_cnt  <= '0;
      busy      <= 1'b0;
      pc        <= '0;
`ifdef STEP_EN
      step_q    <= 1'b0;
      inited    <= 1'b0;
      step_pend <= 1'b0;
`endif
    end else begin
      dda_en <= 1'b0;
`ifdef STEP_EN
      step_q <= step;
`endif
      case (state)
        IDLE: begin
          if (run) begin
            state     <= INIT;
            dda_rst_n <= 1'b0;
            dda_en    <= 1'b1;
            busy      <= 1'b1;
            step_cnt  <= '0;
            pc        <= '0;
`ifdef STEP_EN
            inited    <= 1'b1;
            step_pend <= 1'b0;
`endif
          end
`ifdef STEP_EN
          else if (step_rise) begin
            if (inited) begin
              dda_rst_n <= 1'b1;
              dda_en    <= 1'b1;
              step_cnt  <= step_cnt + CNT_W'(1);
            end else begin
              state     <= INIT;
              dda_rst_n <= 1'b0;
              dda_en    <= 1'b1;
              busy      <= 1'b1;
              step_cnt  <= '0;
              pc        <= '0;
              inited    <= 1'b1;
              step_pend <= 1'b1;
            end
          end
`endif
        end
        INIT: begin
          dda_rst_n <= 1'b1;
          dda_en    <= 1'b1;
          step_cnt  <= step_cnt + CNT_W'(1);
          pc        <= '0;
          state     <= RUN;
`ifdef STEP_EN
          if (step_pend) begin
            state     <= IDLE;
            busy      <= 1'b0;
            step_pend <= 1'b0;
          end
`endif
        end
        RUN: begin
          if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pc == presc) begin
            dda_en   <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
            pc       <= '0;
          end else begin
            pc <= pc + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dda_param_loader.sv
// tb_dda_param_loader: directed self-checking bench for dda_param_loader (N=16).
// Honours STEP_EN when defined for both the bench and the design.
module tb_dda_param_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        ptr_clr = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [15:0] ic1, ic2, vK_M, vD_M, dt;
  logic        dda_rst_n, dda_en, busy, err;
  logic [15:0] step_cnt;

  int passed = 0;
  int total  = 0;

  dda_param_loader #(.N(16), .ES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .ptr_clr(ptr_clr), .run(run), .step(step),
    .ic1(ic1), .ic2(ic2), .vK_M(vK_M), .vD_M(vD_M), .dt(dt),
    .dda_rst_n(dda_rst_n), .dda_en(dda_en), .step_cnt(step_cnt),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic write_all(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input logic [15:0] e, input logic [7:0] p);
    ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0;
    write_byte(a[7:0]); write_byte(a[15:8]);
    write_byte(b[7:0]); write_byte(b[15:8]);
    write_byte(c[7:0]); write_byte(c[15:8]);
    write_byte(d[7:0]); write_byte(d[15:8]);
    write_byte(e[7:0]); write_byte(e[15:8]);
    write_byte(p);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++; if ({dda_rst_n, dda_en, busy, err} !== 4'b0000) $display("[TB] FAIL reset_ctrl got %b want 0000", {dda_rst_n, dda_en, busy, err}); else passed++;
    total++; if (step_cnt !== 16'd0) $display("[TB] FAIL reset_cnt got %0d want 0", step_cnt); else passed++;
    total++; if ({ic1, dt} !== 32'd0) $display("[TB] FAIL reset_regs got %h want 0", {ic1, dt}); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_map;
    for (int i = 1; i <= 11; i++) write_byte(8'(i));
    total++; if (ic1 !== 16'h0201) $display("[TB] FAIL map_ic1 got %h want 0201", ic1); else passed++;
    total++; if (ic2 !== 16'h0403) $display("[TB] FAIL map_ic2 got %h want 0403", ic2); else passed++;
    total++; if (vK_M !== 16'h0605) $display("[TB] FAIL map_vKM got %h want 0605", vK_M); else passed++;
    total++; if (vD_M !== 16'h0807) $display("[TB] FAIL map_vDM got %h want 0807", vD_M); else passed++;
    total++; if (dt !== 16'h0A09) $display("[TB] FAIL map_dt got %h want 0A09", dt); else passed++;
    write_byte(8'hAA);
    total++; if (ic1 !== 16'h02AA) $display("[TB] FAIL ptr_wrap got %h want 02AA", ic1); else passed++;
  endtask

  task automatic test_run_presc0;
    write_all(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 8'h00);
    run = 1'b1;
    tick();
    total++; if ({dda_rst_n, dda_en, busy} !== 3'b011) $display("[TB] FAIL p0_init got %b want 011", {dda_rst_n, dda_en, busy}); else passed++;
    total++; if (step_cnt !== 16'd0) $display("[TB] FAIL p0_init_cnt got %0d want 0", step_cnt); else passed++;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total++; if ({dda_rst_n, dda_en} !== 2'b11 || step_cnt !== 16'(c)) $display("[TB] FAIL p0_run%0d got rst/en %b cnt %0d want 11 cnt %0d", c, {dda_rst_n, dda_en}, step_cnt, c); else passed++;
    end
    run = 1'b0;
    tick();
    total++; if ({dda_rst_n, dda_en, busy} !== 3'b100) $display("[TB] FAIL p0_stop got %b want 100", {dda_rst_n, dda_en, busy}); else passed++;
    total++; if (step_cnt !== 16'd5) $display("[TB] FAIL p0_cnt got %0d want 5", step_cnt); else passed++;
  endtask

  task automatic test_run_presc3;
    write_all(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 8'h03);
    run = 1'b1;
    tick();
    total++; if ({dda_rst_n, dda_en} !== 2'b01) $display("[TB] FAIL p3_init got %b want 01", {dda_rst_n, dda_en}); else passed++;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (dda_en !== ((c % 4) == 0)) $display("[TB] FAIL p3_en_cycle%0d got %b want %b", c, dda_en, ((c % 4) == 0)); else passed++;
    end
    total++; if (step_cnt !== 16'd3) $display("[TB] FAIL p3_cnt got %0d want 3", step_cnt); else passed++;
    run = 1'b0;
    tick();
  endtask

  task automatic test_write_busy;
    run = 1'b1;
    tick();
    tick();
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    tick();
    wr_en   = 1'b0;
    total++; if (err !== 1'b1) $display("[TB] FAIL busy_err got %b want 1", err); else passed++;
    total++; if (ic1 !== 16'h1111) $display("[TB] FAIL busy_drop got %h want 1111", ic1); else passed++;
    run = 1'b0;
    tick();
    total++; if (err !== 1'b1) $display("[TB] FAIL err_sticky got %b want 1", err); else passed++;
    ptr_clr = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    ptr_clr = 1'b0;
    wr_en   = 1'b0;
    total++; if (err !== 1'b0) $display("[TB] FAIL clr_err got %b want 0", err); else passed++;
    total++; if (ic1 !== 16'h1111) $display("[TB] FAIL clr_drop got %h want 1111", ic1); else passed++;
    write_byte(8'h77);
    total++; if (ic1 !== 16'h1177) $display("[TB] FAIL clr_ptr got %h want 1177", ic1); else passed++;
  endtask

  task automatic test_async_reset;
    run = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({dda_rst_n, dda_en, busy, err} !== 4'b0000) $display("[TB] FAIL areset_ctrl got %b want 0000", {dda_rst_n, dda_en, busy, err}); else passed++;
    total++; if (step_cnt !== 16'd0) $display("[TB] FAIL areset_cnt got %0d want 0", step_cnt); else passed++;
    total++; if (ic1 !== 16'h0000) $display("[TB] FAIL areset_regs got %h want 0000", ic1); else passed++;
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if ({dda_en, busy} !== 2'b00) $display("[TB] FAIL areset_idle got %b want 00", {dda_en, busy}); else passed++;
  endtask

`ifdef STEP_EN
  task automatic test_step;
    step = 1'b1;
    tick();
    total++; if ({dda_rst_n, dda_en, busy} !== 3'b011) $display("[TB] FAIL step_init got %b want 011", {dda_rst_n, dda_en, busy}); else passed++;
    tick();
    total++; if ({dda_rst_n, dda_en} !== 2'b11 || step_cnt !== 16'd1) $display("[TB] FAIL step1 got %b cnt %0d want 11 cnt 1", {dda_rst_n, dda_en}, step_cnt); else passed++;
    tick();
    total++; if (dda_en !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL step1_end got en %b busy %b want 0 0", dda_en, busy); else passed++;
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    total++; if ({dda_rst_n, dda_en} !== 2'b11 || step_cnt !== 16'd2) $display("[TB] FAIL step2 got %b cnt %0d want 11 cnt 2", {dda_rst_n, dda_en}, step_cnt); else passed++;
    tick();
    total++; if (dda_en !== 1'b0 || step_cnt !== 16'd2) $display("[TB] FAIL step2_end got en %b cnt %0d want 0 cnt 2", dda_en, step_cnt); else passed++;
    step = 1'b0;
    tick();
  endtask
`else
  task automatic test_step;
    step = 1'b1;
    tick();
    total++; if ({dda_en, busy} !== 2'b00) $display("[TB] FAIL step_ignored got %b want 00", {dda_en, busy}); else passed++;
    tick();
    total++; if (dda_en !== 1'b0 || step_cnt !== 16'd0) $display("[TB] FAIL step_ignored2 got en %b cnt %0d want 0 cnt 0", dda_en, step_cnt); else passed++;
    step = 1'b0;
    tick();
  endtask
`endif

  // Runs every scenario in order and reports the tally.
  initial begin
    test_reset();
    test_write_map();
    test_run_presc0();
    test_run_presc3();
    test_write_busy();
    test_async_reset();
    test_step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
